// File: rtl/rs_pkg.sv
// Shared widths, entry record and CDB wakeup helper for the reservation station.
package rs_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 10;
    localparam int unsigned TAG_W = 5;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   Op;
        logic [TAG_W-1:0]  Qj;
        logic [TAG_W-1:0]  Qk;
        logic [XLEN-1:0]   Vj;
        logic [XLEN-1:0]   Vk;
        logic [XLEN-1:0]   A;
        logic [TAG_W-1:0]  Dest;
    } rs_entry_t;

    // Fill each operand independently when its tag matches the broadcast.
    function automatic rs_entry_t rs_wake(input rs_entry_t        e,
                                          input logic             hit,
                                          input logic [TAG_W-1:0] tag,
                                          input logic [XLEN-1:0]  value);
        rs_entry_t r;
        r = e;
        if (hit && (e.Qj == tag)) begin
            r.Qj = '0;
            r.Vj = value;
        end
        if (hit && (e.Qk == tag)) begin
            r.Qk = '0;
            r.Vk = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority picker: one-hot grant plus encoded index of the winner.
module rs_select #(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req_i,
    output logic [DEPTH-1:0]         gnt_c,
    output logic [$clog2(DEPTH)-1:0] idx_c,
    output logic                     any_c
);

    localparam int unsigned IW = $clog2(DEPTH);

    // Walk from the top so the lowest requesting index is written last.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_c    = '0;
                gnt_c[i] = 1'b1;
                idx_c    = IW'(i);
                any_c    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Age-ordered collapsing reservation station with CDB wakeup and oldest-ready dispatch.
// Optional RS_CDB_BYPASS_EN lets an entry woken by this cycle's broadcast dispatch immediately.
module reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = rs_pkg::TAG_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [rs_pkg::OP_W-1:0]     in_Op,
    input  logic [TAG_W-1:0]            in_Qj,
    input  logic [TAG_W-1:0]            in_Qk,
    input  logic [rs_pkg::XLEN-1:0]     in_Vj,
    input  logic [rs_pkg::XLEN-1:0]     in_Vk,
    input  logic [rs_pkg::XLEN-1:0]     in_A,
    input  logic [TAG_W-1:0]            in_Dest,
    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [rs_pkg::XLEN-1:0]     cdb_value,
    input  logic                        flush,
    output logic                        ex_valid,
    input  logic                        ex_ready,
    output logic [rs_pkg::OP_W-1:0]     ex_Op,
    output logic [rs_pkg::XLEN-1:0]     ex_Vj,
    output logic [rs_pkg::XLEN-1:0]     ex_Vk,
    output logic [rs_pkg::XLEN-1:0]     ex_A,
    output logic [TAG_W-1:0]            ex_Dest,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    import rs_pkg::*;

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned ETW = rs_pkg::TAG_W;

    rs_entry_t         ent_q  [DEPTH];
    rs_entry_t         ent_d  [DEPTH];
    rs_entry_t         woke_c [DEPTH];
    rs_entry_t         new_c;
    logic [CW-1:0]     count_q, count_d, base_c;
    logic [DEPTH-1:0]  rdy_c, gnt_c;
    logic [IW-1:0]     sel_idx_c;
    logic              sel_any_c;
    logic              cdb_hit_c, accept_c, dispatch_c;
    logic [ETW-1:0]    cdb_tag_c;

    assign cdb_tag_c  = ETW'(cdb_tag);
    assign cdb_hit_c  = cdb_valid && (cdb_tag != '0);
    assign in_ready   = (count_q < CW'(DEPTH));
    assign count      = count_q;
    assign ex_valid   = sel_any_c && !flush;
    assign dispatch_c = ex_valid && ex_ready;
    assign accept_c   = in_valid && in_ready && !flush;

    // Wakeup view of every entry and the readiness vector fed to the picker.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke_c[i] = rs_wake(ent_q[i], cdb_hit_c, cdb_tag_c, cdb_value);
`ifdef RS_CDB_BYPASS_EN
            rdy_c[i]  = woke_c[i].valid && (woke_c[i].Qj == '0) && (woke_c[i].Qk == '0);
`else
            rdy_c[i]  = ent_q[i].valid && (ent_q[i].Qj == '0) && (ent_q[i].Qk == '0);
`endif
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_select (
        .req_i (rdy_c),
        .gnt_c (gnt_c),
        .idx_c (sel_idx_c),
        .any_c (sel_any_c)
    );

    // Offered payload; zero whenever nothing is offered.
    always_comb begin
        ex_Op   = '0;
        ex_Vj   = '0;
        ex_Vk   = '0;
        ex_A    = '0;
        ex_Dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt_c[i] && !flush) begin
                ex_Op   = woke_c[i].Op;
                ex_Vj   = woke_c[i].Vj;
                ex_Vk   = woke_c[i].Vk;
                ex_A    = woke_c[i].A;
                ex_Dest = TAG_W'(woke_c[i].Dest);
            end
        end
    end

    // Incoming entry, capturing a same-cycle broadcast of either source.
    always_comb begin
        new_c       = '0;
        new_c.valid = 1'b1;
        new_c.Op    = in_Op;
        new_c.A     = in_A;
        new_c.Dest  = ETW'(in_Dest);
        if (cdb_hit_c && (in_Qj == cdb_tag)) begin
            new_c.Qj = '0;
            new_c.Vj = cdb_value;
        end else begin
            new_c.Qj = ETW'(in_Qj);
            new_c.Vj = in_Vj;
        end
        if (cdb_hit_c && (in_Qk == cdb_tag)) begin
            new_c.Qk = '0;
            new_c.Vk = cdb_value;
        end else begin
            new_c.Qk = ETW'(in_Qk);
            new_c.Vk = in_Vk;
        end
    end

    // Collapse above the dispatched slot, then append the new entry at the tail.
    always_comb begin
        base_c = count_q - CW'(dispatch_c);
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = (dispatch_c && (IW'(i) >= sel_idx_c)) ? woke_c[i + 1] : woke_c[i];
        end
        ent_d[DEPTH-1] = dispatch_c ? '0 : woke_c[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (accept_c && (base_c == CW'(i))) begin
                ent_d[i] = new_c;
            end
        end
        count_d = base_c + CW'(accept_c);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: per-cycle vector table plus full and flush sequences.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_Op;
    logic [4:0]  in_Qj, in_Qk, in_Dest;
    logic [31:0] in_Vj, in_Vk, in_A;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [9:0]  ex_Op;
    logic [31:0] ex_Vj, ex_Vk, ex_A;
    logic [4:0]  ex_Dest;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    reservation_station #(.DEPTH(4), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_Op(in_Op),
        .in_Qj(in_Qj), .in_Qk(in_Qk), .in_Vj(in_Vj), .in_Vk(in_Vk),
        .in_A(in_A), .in_Dest(in_Dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_Op(ex_Op),
        .ex_Vj(ex_Vj), .ex_Vk(ex_Vk), .ex_A(ex_A), .ex_Dest(ex_Dest),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  qj, qk;
        logic [31:0] vj, vk;
        logic [4:0]  dest;
        logic        cv;
        logic [4:0]  ct;
        logic [31:0] cval;
        logic        er;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic        e_ev;
        logic [31:0] e_vj, e_vk;
        logic [4:0]  e_dest;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [4:0] qj, logic [4:0] qk, logic [31:0] vj,
                                logic [31:0] vk, logic [4:0] dest, logic cv, logic [4:0] ct,
                                logic [31:0] cval, logic er, logic e_rdy, logic [2:0] e_cnt,
                                logic e_ev, logic [31:0] e_vj, logic [31:0] e_vk,
                                logic [4:0] e_dest);
        vec_t r;
        r.v = v; r.qj = qj; r.qk = qk; r.vj = vj; r.vk = vk; r.dest = dest;
        r.cv = cv; r.ct = ct; r.cval = cval; r.er = er;
        r.e_rdy = e_rdy; r.e_cnt = e_cnt; r.e_ev = e_ev;
        r.e_vj = e_vj; r.e_vk = e_vk; r.e_dest = e_dest;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] qj, input logic [4:0] qk,
                         input logic [31:0] vj, input logic [31:0] vk, input logic [4:0] dest,
                         input logic cv, input logic [4:0] ct, input logic [31:0] cval,
                         input logic fl, input logic er);
        in_valid  = v;
        in_Qj     = qj;
        in_Qk     = qk;
        in_Vj     = vj;
        in_Vk     = vk;
        in_Dest   = dest;
        in_Op     = 10'h200 | 10'(dest);
        in_A      = 32'h100 + 32'(dest);
        cdb_valid = cv;
        cdb_tag   = ct;
        cdb_value = cval;
        flush     = fl;
        ex_ready  = er;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Op and A of an offered entry are derived from its Dest by the drive task.
    task automatic check_out(input string nm, input logic e_rdy, input logic [2:0] e_cnt,
                             input logic e_ev, input logic [31:0] e_vj, input logic [31:0] e_vk,
                             input logic [4:0] e_dest);
        chk($sformatf("%s.in_ready", nm), 32'(in_ready), 32'(e_rdy));
        chk($sformatf("%s.count", nm),    32'(count),    32'(e_cnt));
        chk($sformatf("%s.ex_valid", nm), 32'(ex_valid), 32'(e_ev));
        chk($sformatf("%s.ex_Vj", nm),    ex_Vj,         e_vj);
        chk($sformatf("%s.ex_Vk", nm),    ex_Vk,         e_vk);
        chk($sformatf("%s.ex_Dest", nm),  32'(ex_Dest),  32'(e_dest));
        chk($sformatf("%s.ex_Op", nm),    32'(ex_Op),
            e_ev ? 32'(10'h200 | 10'(e_dest)) : 32'h0);
        chk($sformatf("%s.ex_A", nm),     ex_A, e_ev ? 32'h100 + 32'(e_dest) : 32'h0);
    endtask

    task automatic idle(input logic er);
        drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, er);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-issue dispatch, delayed wakeup, age ordering, issue capture,
        // issue+dispatch same cycle, tag-0 broadcast ignored, shift with wakeup.
        vecs.push_back(mk(1, 0, 0, 5, 7, 1,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 1, 1, 5, 7, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 8, 2,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 3, 32'h1234, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 1, 1, 32'h1234, 8, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 3,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 10, 11, 4,        0, 0, 0, 0,        1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 2, 1, 10, 11, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 2, 9, 1,        1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 1, 1, 9, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 6, 32'h21, 0, 5,     1, 6, 32'h55, 1,   1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 1, 1, 32'h21, 32'h55, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2, 6,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 3, 4, 7,          0, 0, 0, 1,        1, 1, 1, 1, 2, 6));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 1, 1, 3, 4, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h11, 32'h22, 9, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 9, 0, 0, 8,          0, 0, 0, 0,        1, 1, 1, 32'h11, 32'h22, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 0, 32'hdead, 0, 1, 2, 1, 32'h11, 32'h22, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          1, 9, 32'h77, 1,   1, 2, 1, 32'h11, 32'h22, 9));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 1, 1, 32'h77, 32'h77, 8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 1,        1, 0, 0, 0, 0, 0));

        rst_n = 1'b0;
        idle(1'b1);
        repeat (2) @(negedge clk);
        #1 check_out("reset", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].qj, vecs[i].qk, vecs[i].vj, vecs[i].vk, vecs[i].dest,
                  vecs[i].cv, vecs[i].ct, vecs[i].cval, 1'b0, vecs[i].er);
            #1 check_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_cnt, vecs[i].e_ev,
                         vecs[i].e_vj, vecs[i].e_vk, vecs[i].e_dest);
        end

        // Fill with four waiting entries (tags 10..13), then try a fifth.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(10 + k), 5'd0, 32'h0, 32'(10 + k), 5'(10 + k),
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
            #1 check_out($sformatf("fill%0d", k), 1, 3'(k), 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 32'h99, 32'h98, 5'd14, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        #1 check_out("full_reject", 0, 4, 0, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd12, 32'hc12, 1'b0, 1'b1);
        #1 check_out("full_wake12", 0, 4, 0, 0, 0, 0);
        @(negedge clk);
        idle(1'b1);
        #1 check_out("full_disp12", 0, 4, 1, 32'hc12, 12, 12);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd13, 32'hd13, 1'b0, 1'b0);
        #1 check_out("after_full", 1, 3, 0, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd10, 32'ha10, 1'b0, 1'b0);
        #1 check_out("offer13", 1, 3, 1, 32'hd13, 13, 13);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 5'd11, 32'hb11, 1'b0, 1'b0);
        #1 check_out("offer10", 1, 3, 1, 32'ha10, 10, 10);
        @(negedge clk);
        idle(1'b1);
        #1 check_out("drain10", 1, 3, 1, 32'ha10, 10, 10);
        @(negedge clk);
        idle(1'b1);
        #1 check_out("drain11", 1, 2, 1, 32'hb11, 11, 11);
        @(negedge clk);
        idle(1'b1);
        #1 check_out("drain13", 1, 1, 1, 32'hd13, 13, 13);
        @(negedge clk);
        idle(1'b0);
        #1 check_out("drained", 1, 0, 0, 0, 0, 0);

        // Three ready entries held, then flush with a same-cycle issue.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 5'd0, 5'd0, 32'(32'h40 + k), 32'(32'h50 + k), 5'(20 + k),
                  1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
            if (k == 0) #1 check_out("hold0", 1, 0, 0, 0, 0, 0);
            else        #1 check_out($sformatf("hold%0d", k), 1, 3'(k), 1, 32'h40, 32'h50, 20);
        end
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 32'h61, 32'h62, 5'd25, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        #1 check_out("flush_cycle", 1, 3, 0, 0, 0, 0);
        @(negedge clk);
        idle(1'b1);
        #1 check_out("post_flush", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        idle(1'b1);
        #1 check_out("post_flush2", 1, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Issue-side reservation station for the out-of-order RV32I core. It accepts renamed, decoded instructions (Op, operand tags or values, address immediate, destination tag) and holds them until both operands are available. It snoops the common data bus (CDB) for results and dispatches the oldest ready entry to the execute unit. It sits between the rename/issue stage, which consumes the decoder bundle, and the ALU/branch unit.

## Interface
- DEPTH, 4: number of entries, 2..16
- TAG_W, 5: ROB tag width; tag 0 means "value present"
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  issue request
- in_ready  out  1  entry free (count < DEPTH)
- in_Op  in  10  {funct3, funct7}
- in_Qj, in_Qk  in  TAG_W  source tags; 0 = value in in_Vj/in_Vk
- in_Vj, in_Vk  in  32  source values
- in_A  in  32  address/immediate, passed through
- in_Dest  in  TAG_W  destination ROB tag
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producing tag; 0 is ignored
- cdb_value  in  32  result
- flush  in  1  mispredict squash
- ex_valid  out  1  ready entry offered
- ex_ready  in  1  execute unit accepts
- ex_Op, ex_Vj, ex_Vk, ex_A, ex_Dest  out  10/32/32/32/TAG_W  payload of the offered entry
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entries form a collapsing queue in age order; index 0 is oldest. Issue writes slot `count`. On dispatch, entries above the dispatched slot shift down by one.
- An entry is ready when both Qj == 0 and Qk == 0.
- Selection: the lowest-index ready entry. ex_valid = 1 if any entry is ready. The payload is zero when ex_valid = 0.
- Dispatch occurs when ex_valid && ex_ready; the entry is removed at that edge.
- CDB wakeup applies per entry when cdb_valid && cdb_tag != 0:
  - if Qj == cdb_tag, then Vj <= cdb_value and Qj <= 0;
  - Qk is handled independently. Qj == Qk == cdb_tag fills both.
- Issue capture: if in_Qj (or in_Qk) equals a valid nonzero cdb_tag in the issue cycle, the stored value is cdb_value and the stored tag is 0.
- Simultaneous issue and dispatch: the new entry lands at index count-1, after the collapse. count is unchanged.
- flush has priority. At the edge:
  - all entries are invalidated and count becomes 0;
  - any issue that cycle is dropped;
  - ex_valid is forced 0 during the flush cycle.
- Reset values: count 0, in_ready 1, ex_valid 0, all ex payload 0, and all stored tags and values 0.

## Timing
- in_ready and count are functions of registered state only.
- An issued entry is visible the cycle after acceptance; there is no issue-to-dispatch bypass. Minimum issue-to-dispatch latency is 1 cycle.
- ex_* are combinational from entry state (plus the CDB when RS_CDB_BYPASS_EN is defined). The offered entry may change while ex_ready = 0, for example when an older entry wakes. The consumer samples only on ex_valid && ex_ready.
- When full, in_ready = 0 even if a dispatch happens this cycle.
- The wakeup write lands at the same edge as a shift. A shifting entry carries its updated operands into its new slot.

## Configuration
- RS_CDB_BYPASS_EN defined:
  - an entry whose only outstanding tag(s) match this cycle's valid cdb_tag counts as ready this cycle;
  - ex_Vj/ex_Vk forward cdb_value;
  - wakeup-to-dispatch is 0 cycles.
  - Priority stays lowest index among ready or bypass-ready entries.
- Undefined: a woken entry becomes eligible the cycle after the broadcast (wakeup-to-dispatch 1 cycle).

## Structure
- rs_pkg holds:
  - XLEN = 32, OP_W = 10, TAG_W default;
  - typedef rs_entry_t {valid, Op, Qj, Qk, Vj, Vk, A, Dest}.
- Sub-module rs_select: a DEPTH-wide lowest-index priority picker that returns the one-hot grant and the index.

## Test plan
- Issue Op=0, Qj=Qk=0, Vj=5, Vk=7, ex_ready=1 -> next cycle ex_valid=1, ex_Vj=5, ex_Vk=7; count returns to 0 after the accept.
- Issue with Qj=3; two cycles later cdb_tag=3, cdb_value=0x1234 -> dispatch the following cycle with ex_Vj=0x1234 (the same cycle if RS_CDB_BYPASS_EN).
- Issue A (Qj=2) then B (ready) -> B dispatches first. Then cdb_tag=2, value 9 -> A dispatches with Vj=9.
- Issue in_Qk=6 while cdb_valid, tag 6, value 0x55 -> the entry stores Vk=0x55 and dispatches the next cycle.
- DEPTH=4: four waiting entries -> in_ready=0, and a 5th in_valid is ignored. Wake one and dispatch -> in_ready=1; remaining order is preserved.
- Three entries with ex_ready=0, then assert flush -> ex_valid=0 that cycle, count=0 after; a same-cycle issue is dropped.
